// File: rtl/mix_columns_engine.sv
// Sequential AES MixColumns / InvMixColumns engine over a 128-bit column-major state.
// Transforms COLS_PER_CYCLE columns per clock in place, with valid/ready on both sides.
module mix_columns_engine #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int N_STEPS = 4 / ((COLS_PER_CYCLE > 0) ? COLS_PER_CYCLE : 1);
  localparam logic [1:0] LAST_STEP = 2'(N_STEPS - 1);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t       state_q, state_d;
  logic [127:0] work_q, work_d;
  logic         mode_q, mode_d;
  logic [1:0]   step_q, step_d;
  logic         accept_s;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    xtime = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul2(input logic [7:0] a);
    mul2 = xtime(a);
  endfunction

  function automatic logic [7:0] mul3(input logic [7:0] a);
    mul3 = xtime(a) ^ a;
  endfunction

  // The inverse coefficients are sums of a, 2a, 4a and 8a from one xtime chain.
  function automatic logic [7:0] mul9(input logic [7:0] a);
    mul9 = xtime(xtime(xtime(a))) ^ a;
  endfunction

  function automatic logic [7:0] mulb(input logic [7:0] a);
    mulb = xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
  endfunction

  function automatic logic [7:0] muld(input logic [7:0] a);
    muld = xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
  endfunction

  function automatic logic [7:0] mule(input logic [7:0] a);
    mule = xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
    logic [7:0] s0, s1, s2, s3;
    s0 = col[31:24];
    s1 = col[23:16];
    s2 = col[15:8];
    s3 = col[7:0];
    if (inv) begin
      mix_col = {mule(s0) ^ mulb(s1) ^ muld(s2) ^ mul9(s3),
                 mul9(s0) ^ mule(s1) ^ mulb(s2) ^ muld(s3),
                 muld(s0) ^ mul9(s1) ^ mule(s2) ^ mulb(s3),
                 mulb(s0) ^ muld(s1) ^ mul9(s2) ^ mule(s3)};
    end else begin
      mix_col = {mul2(s0) ^ mul3(s1) ^ s2 ^ s3,
                 s0 ^ mul2(s1) ^ mul3(s2) ^ s3,
                 s0 ^ s1 ^ mul2(s2) ^ mul3(s3),
                 mul3(s0) ^ s1 ^ s2 ^ mul2(s3)};
    end
  endfunction

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept_s  = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == BUSY);
  assign out_data  = work_q;

  // State register, work register, latched mode and step counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= 128'd0;
      mode_q  <= 1'b0;
      step_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      mode_q  <= mode_d;
      step_q  <= step_d;
    end
  end

  // Next-state logic: acceptance, per-step column transform, output handshake
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    mode_d  = mode_q;
    step_d  = step_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept_s) begin
          work_d  = in_data;
          mode_d  = in_inv;
          step_d  = 2'd0;
          state_d = BUSY;
        end else if (state_q == DONE && out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = state_q;
        end
      end
      BUSY: begin
        // Each column reads only its own pre-step bytes, so in-place update is safe.
        for (int c = 0; c < 4; c++) begin
          if ((c / COLS_PER_CYCLE) == int'(step_q)) begin
            work_d[127-32*c -: 32] = mix_col(work_q[127-32*c -: 32], mode_q);
          end else begin
            work_d[127-32*c -: 32] = work_q[127-32*c -: 32];
          end
        end
        if (step_q == LAST_STEP) begin
          step_d  = 2'd0;
          state_d = DONE;
        end else begin
          step_d  = step_q + 2'd1;
          state_d = BUSY;
        end
      end
      default: begin
        state_d = IDLE;
        step_d  = 2'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_mix_columns_engine.sv
// Directed bench for mix_columns_engine: three instances (1, 2 and 4 columns per cycle)
// checked against hand-computed AES MixColumns / InvMixColumns vectors.
module tb_mix_columns_engine;

  logic         clk;
  logic         rst;
  logic [2:0]   in_valid;
  logic [2:0]   in_ready;
  logic [2:0]   in_inv;
  logic [2:0]   out_valid;
  logic [2:0]   out_ready;
  logic [2:0]   busy;
  logic [127:0] in_data  [3];
  logic [127:0] out_data [3];

  int n_checks;
  int n_pass;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int C = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    mix_columns_engine #(.COLS_PER_CYCLE(C)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .in_inv    (in_inv[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g]),
      .busy      (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] FWD_IN  = {32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6};
  localparam logic [127:0] FWD_OUT = {32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6};
  localparam logic [127:0] INV_IN  = {32'h8e4da1bc, 32'h9fdc589d, 32'h4d7ebdf8, 32'hd5d5d7d6};
  localparam logic [127:0] INV_OUT = {32'hdb135345, 32'hf20a225c, 32'h2d26314c, 32'hd4d4d4d5};

  // Presents one state and holds it until the accepting edge; returns 1 ns after that edge.
  task automatic send(input int d, input logic [127:0] data, input logic inv);
    int n;
    n = 0;
    in_valid[d] = 1'b1;
    in_data[d]  = data;
    in_inv[d]   = inv;
    while (!in_ready[d] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready[d]) begin
      n_checks++;
      $display("FAIL send_timeout dut%0d: in_ready stayed 0", d);
    end
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    in_data[d]  = 'x;
  endtask

  // Waits for out_valid, reporting the edges elapsed and the presented data.
  task automatic wait_out(input int d, output logic [127:0] data, output int cyc);
    cyc = 0;
    while (!out_valid[d] && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!out_valid[d]) begin
      n_checks++;
      $display("FAIL out_timeout dut%0d: out_valid stayed 0", d);
    end
    data = out_data[d];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if ({in_ready[d], out_valid[d], busy[d]} !== 3'b100) $display("FAIL reset_flags dut%0d: got %b want 100", d, {in_ready[d], out_valid[d], busy[d]});
      else n_pass++;
      n_checks++;
      if (out_data[d] !== 128'd0) $display("FAIL reset_data dut%0d: got %h want 0", d, out_data[d]);
      else n_pass++;
    end
  endtask

  task automatic test_forward_c1();
    logic [127:0] got;
    int cyc;
    send(0, FWD_IN, 1'b0);
    n_checks++;
    if (busy[0] !== 1'b1) $display("FAIL fwd_busy: got %b want 1", busy[0]);
    else n_pass++;
    wait_out(0, got, cyc);
    n_checks++;
    if (cyc != 4) $display("FAIL fwd_latency: got %0d want 4", cyc);
    else n_pass++;
    n_checks++;
    if (got !== FWD_OUT) $display("FAIL fwd_data: got %h want %h", got, FWD_OUT);
    else n_pass++;
    n_checks++;
    if (busy[0] !== 1'b0) $display("FAIL fwd_busy_done: got %b want 0", busy[0]);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({out_valid[0], in_ready[0]} !== 2'b01) $display("FAIL fwd_drain: got %b want 01", {out_valid[0], in_ready[0]});
    else n_pass++;
  endtask

  task automatic test_inverse_c4();
    logic [127:0] got;
    int cyc;
    send(2, INV_IN, 1'b1);
    wait_out(2, got, cyc);
    n_checks++;
    if (cyc != 1) $display("FAIL inv_latency: got %0d want 1", cyc);
    else n_pass++;
    n_checks++;
    if (got !== INV_OUT) $display("FAIL inv_data: got %h want %h", got, INV_OUT);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [127:0] got;
    int cyc;
    out_ready[1] = 1'b0;
    send(1, FWD_IN, 1'b0);
    wait_out(1, got, cyc);
    n_checks++;
    if (cyc != 2) $display("FAIL bp_latency: got %0d want 2", cyc);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (out_data[1] !== FWD_OUT || in_ready[1] !== 1'b0 || out_valid[1] !== 1'b1)
        $display("FAIL bp_hold cycle %0d: data %h ready %b valid %b want %h 0 1", i, out_data[1], in_ready[1], out_valid[1], FWD_OUT);
      else n_pass++;
      @(posedge clk); #1;
    end
    out_ready[1] = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({in_ready[1], out_valid[1]} !== 2'b10) $display("FAIL bp_release: got %b want 10", {in_ready[1], out_valid[1]});
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [127:0] got;
    int cyc;
    send(0, FWD_IN, 1'b0);
    wait_out(0, got, cyc);
    in_valid[0] = 1'b1;
    in_data[0]  = {4{32'h2d26314c}};
    in_inv[0]   = 1'b0;
    #1;
    n_checks++;
    if (in_ready[0] !== 1'b1) $display("FAIL b2b_ready: got %b want 1", in_ready[0]);
    else n_pass++;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    n_checks++;
    if ({out_valid[0], busy[0]} !== 2'b01) $display("FAIL b2b_accept: got %b want 01", {out_valid[0], busy[0]});
    else n_pass++;
    wait_out(0, got, cyc);
    n_checks++;
    if (got !== {4{32'h4d7ebdf8}}) $display("FAIL b2b_data: got %h want %h", got, {4{32'h4d7ebdf8}});
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [127:0] got;
    int cyc;
    send(0, INV_IN, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    in_valid[0] = 1'b1;
    in_data[0]  = FWD_IN;
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid[0] = 1'b0;
    n_checks++;
    if ({in_ready[0], out_valid[0], busy[0]} !== 3'b100 || out_data[0] !== 128'd0)
      $display("FAIL mid_reset: flags %b data %h want 100 0", {in_ready[0], out_valid[0], busy[0]}, out_data[0]);
    else n_pass++;
    send(0, FWD_IN, 1'b0);
    wait_out(0, got, cyc);
    n_checks++;
    if (got !== FWD_OUT) $display("FAIL mid_recover: got %h want %h", got, FWD_OUT);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_mode_isolation();
    logic [127:0] got;
    int cyc;
    int n;
    for (int m = 0; m < 2; m++) begin
      send(1, (m == 0) ? FWD_IN : INV_IN, (m == 0) ? 1'b0 : 1'b1);
      n = 0;
      while (busy[1] && n < 20) begin
        in_inv[1] = ~in_inv[1];
        @(posedge clk); #1;
        n++;
      end
      wait_out(1, got, cyc);
      n_checks++;
      if (got !== ((m == 0) ? FWD_OUT : INV_OUT)) $display("FAIL mode_iso%0d: got %h want %h", m, got, (m == 0) ? FWD_OUT : INV_OUT);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_round_trip();
    logic [127:0] orig, fwd, back;
    int cyc;
    for (int i = 0; i < 1000; i++) begin
      orig = {$urandom, $urandom, $urandom, $urandom};
      send(2, orig, 1'b0);
      wait_out(2, fwd, cyc);
      send(2, fwd, 1'b1);
      wait_out(2, back, cyc);
      n_checks++;
      if (back !== orig) $display("FAIL round_trip %0d: got %h want %h", i, back, orig);
      else n_pass++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rst       = 1'b0;
    in_valid  = 3'b000;
    in_inv    = 3'b000;
    out_ready = 3'b111;
    for (int d = 0; d < 3; d++) in_data[d] = 128'd0;
    test_reset();
    test_forward_c1();
    test_inverse_c4();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_mode_isolation();
    test_round_trip();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
